// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch stage with a DEPTH-entry queue.
// Fetches over a req/ack handshake and redirects on jp/pcnew.
module fetch_queue #(
    parameter int              AW      = 16,
    parameter int              IW      = 16,
    parameter int              DEPTH   = 4,
    parameter int              PC_STEP = 2,
    parameter logic [AW-1:0]   RST_PC  = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [AW-1:0]            imem_addr,
    input  logic                     imem_ack,
    input  logic [IW-1:0]            imem_data,
    output logic [IW-1:0]            ir,
    output logic [AW-1:0]            pc,
    output logic                     irr,
    input  logic                     take,
    input  logic                     jp,
    input  logic [AW-1:0]            pcnew,
    output logic [$clog2(DEPTH):0]   qcnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CAP  = CW'(DEPTH);
    localparam logic [AW-1:0] STEP = AW'(PC_STEP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t          state;
    state_t          state_d;

    logic [AW-1:0]   fpc;
    logic [AW-1:0]   fpc_d;
    logic            req_d;
    logic [AW-1:0]   addr_d;

    logic [IW-1:0]   q_ir [DEPTH];
    logic [AW-1:0]   q_pc [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    logic            push;
    logic            pop;
    logic [CW-1:0]   cnt_d;
    logic            room;
    logic [AW-1:0]   seq_addr;

    // head of queue goes to decode; an empty queue shows NOP at the fetch PC
    assign irr = (qcnt != '0);
    assign ir  = irr ? q_ir[rd_ptr] : '0;
    assign pc  = irr ? q_pc[rd_ptr] : fpc;

    // queue strobes; a jump cancels both the pop and any push this cycle
    always_comb begin
        pop      = take & irr & ~jp;
        push     = (state == S_WAIT) & imem_ack & ~jp;
        seq_addr = imem_addr + STEP;
        if (jp) begin
            cnt_d = '0;
        end else begin
            cnt_d = qcnt + CW'(push) - CW'(pop);
        end
        room = (cnt_d < CAP);
    end

    // next-state and next fetch-side register values
    always_comb begin
        state_d = state;
        fpc_d   = fpc;
        req_d   = imem_req;
        addr_d  = imem_addr;
        unique case (state)
            S_IDLE: begin
                if (jp) begin
                    fpc_d = pcnew;
                end else if (room) begin
                    req_d   = 1'b1;
                    addr_d  = fpc;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (jp) begin
                    fpc_d = pcnew;
                    if (imem_ack) begin
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (imem_ack) begin
                    fpc_d = seq_addr;
                    if (room) begin
                        addr_d = seq_addr;
                    end else begin
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (jp) begin
                    fpc_d = pcnew;
                end
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // fetch PC and registered memory request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc       <= RST_PC;
            imem_req  <= 1'b0;
            imem_addr <= RST_PC;
        end else begin
            fpc       <= fpc_d;
            imem_req  <= req_d;
            imem_addr <= addr_d;
        end
    end

    // queue pointers and occupancy; a jump empties the queue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            qcnt   <= '0;
        end else begin
            if (jp) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
            qcnt <= cnt_d;
        end
    end

    // queue storage; contents are qualified by qcnt so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            q_ir[wr_ptr] <= imem_data;
            q_pc[wr_ptr] <= imem_addr;
        end
    end

endmodule
